game_timer_bank: RTL and testbench

Parametrised bank of independent down-counting game timers, replacing the per-purpose fixed timers (level timeout, score tick).
- Each channel loads a run-time count, decrements on a shared prescaled tick, and signals expiry with a one-cycle pulse.
- Each channel is either one-shot or periodic (auto-reload).
- A global pause freezes all channels, e.g. while a map is being redrawn or on a menu screen.

---
 rtl/game_timer_bank.sv | 110 +++++++++++
 tb/tb_game_timer_bank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_bank.sv
// Bank of independent down-counting timers sharing one prescaled tick.
// Each channel is one-shot or auto-reload; a global pause freezes the whole bank.
module game_timer_bank #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         stop,
  input  logic [NUM_CH-1:0]         periodic,
  input  logic [NUM_CH*CNT_W-1:0]   load_val,
  input  logic                      global_pause,
  output logic [NUM_CH*CNT_W-1:0]   count_out,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         expire
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  // Free-running shared prescaler; start never realigns it.
  assign tick = (ps_q == PS_MAX) && !global_pause;

  always_comb begin
    ps_d = ps_q;
    if (tick) begin
      ps_d = '0;
    end else if (!global_pause) begin
      ps_d = ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rld_q, rld_d;
    logic             mode_q, mode_d;
    logic             exp_q, exp_d;
    logic [CNT_W-1:0] ld;

    assign ld = load_val[gi*CNT_W +: CNT_W];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        rld_q   <= '0;
        mode_q  <= 1'b0;
        exp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rld_q   <= rld_d;
        mode_q  <= mode_d;
        exp_q   <= exp_d;
      end
    end

    // Priority: valid start, then stop, then the tick-driven countdown.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rld_d   = rld_q;
      mode_d  = mode_q;
      exp_d   = 1'b0;
      if (start[gi] && (ld != '0)) begin
        state_d = ST_RUN;
        cnt_d   = ld;
        rld_d   = ld;
        mode_d  = periodic[gi];
      end else if (stop[gi] && (state_q != ST_IDLE)) begin
        state_d = ST_IDLE;
      end else if ((state_q == ST_RUN) && tick) begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (cnt_q == CNT_W'(1)) begin
          exp_d = 1'b1;
          if (mode_q) begin
            cnt_d = rld_q;
          end else begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
    end

    assign count_out[gi*CNT_W +: CNT_W] = cnt_q;
    assign running[gi] = (state_q == ST_RUN);
    assign done[gi]    = (state_q == ST_DONE);
    assign expire[gi]  = exp_q;
  end

endmodule

// File: tb/tb_game_timer_bank.sv
// Scoreboard bench: two banks (prescale 4 and 1); expected expiries are queued at
// stimulus time and a negedge monitor pops and checks each observed pulse.
module tb_game_timer_bank;

  logic        clk;
  logic        resetn;
  logic [1:0]  a_start, a_stop, a_per, b_start, b_stop, b_per;
  logic [63:0] a_load, b_load, a_cnt, b_cnt;
  logic        a_pause, b_pause;
  logic [1:0]  a_run, a_done, a_exp, b_run, b_done, b_exp;
  int          cyc;
  int          n_tests;
  int          n_fail;

  typedef struct {
    int          ch;
    logic [1:0]  bits;
    logic [31:0] cnt;
    logic        dn;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  game_timer_bank #(.NUM_CH(2), .CNT_W(32), .PRESCALE(4)) u_a (
    .clk(clk), .resetn(resetn), .start(a_start), .stop(a_stop), .periodic(a_per),
    .load_val(a_load), .global_pause(a_pause), .count_out(a_cnt), .running(a_run),
    .done(a_done), .expire(a_exp)
  );

  game_timer_bank #(.NUM_CH(2), .CNT_W(32), .PRESCALE(1)) u_b (
    .clk(clk), .resetn(resetn), .start(b_start), .stop(b_stop), .periodic(b_per),
    .load_val(b_load), .global_pause(b_pause), .count_out(b_cnt), .running(b_run),
    .done(b_done), .expire(b_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit isb, input int ch, input logic [1:0] bits,
                      input logic [31:0] cnt, input logic dn, input int c);
    exp_t e;
    e.ch = ch; e.bits = bits; e.cnt = cnt; e.dn = dn; e.cyc = c;
    if (isb) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic mon(input bit isb, input logic [1:0] ex, input logic [63:0] cnt,
                     input logic [1:0] dn);
    exp_t  e;
    string tag;
    tag = isb ? "B" : "A";
    $display("[TB] dut %s expire=%b cycle=%0d", tag, ex, cyc);
    if ((isb && qb.size() == 0) || (!isb && qa.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s_unexpected_expire: got %b, expected none", tag, ex);
    end else begin
      e = isb ? qb.pop_front() : qa.pop_front();
      chk({tag, "_expire_bits"}, 64'(ex), 64'(e.bits));
      chk({tag, "_expire_count"}, 64'(cnt[e.ch*32 +: 32]), 64'(e.cnt));
      chk({tag, "_expire_done"}, 64'(dn[e.ch]), 64'(e.dn));
      if (e.cyc >= 0) chk({tag, "_expire_cycle"}, 64'(cyc), 64'(e.cyc));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (a_exp != 2'b00) mon(1'b0, a_exp, a_cnt, a_done);
        if (b_exp != 2'b00) mon(1'b1, b_exp, b_cnt, b_done);
      end
    end
  end

  initial begin
    int s;
    int last;
    int nchg;
    int g[3];
    logic [31:0] prev;

    n_tests = 0; n_fail = 0;
    resetn = 1'b0;
    a_start = '0; a_stop = '0; a_per = '0; a_load = '0; a_pause = 1'b0;
    b_start = '0; b_stop = '0; b_per = '0; b_load = '0; b_pause = 1'b0;
    #1;
    chk("reset_a_outputs", {a_cnt[31:0] | a_cnt[63:32], 24'd0, a_run, a_done, a_exp}, 64'd0);
    chk("reset_b_outputs", {b_cnt[31:0] | b_cnt[63:32], 24'd0, b_run, b_done, b_exp}, 64'd0);
    repeat (2) step();
    resetn = 1'b1;
    step();

    // One-shot on the prescale-4 bank: 3 -> 2 -> 1 -> 0, then sticky done.
    a_load[31:0] = 32'd3; a_per[0] = 1'b0; a_start[0] = 1'b1;
    step();
    a_start[0] = 1'b0;
    push(1'b0, 0, 2'b01, 32'd0, 1'b1, -1);
    chk("t1_loaded", a_cnt[31:0], 3);
    chk("t1_running", a_run[0], 1);
    prev = 32'd3; last = cyc; nchg = 0; g[0] = 0; g[1] = 0; g[2] = 0;
    for (int k = 0; k < 40 && nchg < 3; k++) begin
      step();
      if (a_cnt[31:0] != prev) begin
        g[nchg] = cyc - last;
        chk("t1_count_seq", a_cnt[31:0], prev - 32'd1);
        prev = a_cnt[31:0];
        last = cyc;
        nchg++;
      end
    end
    chk("t1_num_changes", nchg, 3);
    chk("t1_first_gap_in_1_to_4", (g[0] >= 1 && g[0] <= 4), 1);
    chk("t1_gap2", g[1], 4);
    chk("t1_gap3", g[2], 4);
    repeat (5) step();
    chk("t1_done_sticky", a_done[0], 1);
    chk("t1_not_running", a_run[0], 0);

    // Periodic ch1 on the prescale-1 bank: 2,1,2,1... expiring every 2 cycles.
    b_load[63:32] = 32'd2; b_per[1] = 1'b1; b_start[1] = 1'b1;
    step();
    s = cyc;
    b_start[1] = 1'b0;
    for (int k = 1; k <= 5; k++) push(1'b1, 1, 2'b10, 32'd2, 1'b0, s + 2 * k);
    chk("t2_loaded", b_cnt[63:32], 2);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t2_count", b_cnt[63:32], (k % 2 == 0) ? 2 : 1);
      chk("t2_done_low", b_done[1], 0);
    end
    b_stop[1] = 1'b1;
    step();
    b_stop[1] = 1'b0;
    chk("t2_stopped", b_run[1], 0);
    chk("t2_count_held", b_cnt[63:32], 2);

    // Pause mid-count: expiry lands 17 cycles after the load.
    b_load[31:0] = 32'd10; b_per[0] = 1'b0; b_start[0] = 1'b1;
    step();
    s = cyc;
    b_start[0] = 1'b0;
    push(1'b1, 0, 2'b01, 32'd0, 1'b1, s + 17);
    repeat (3) step();
    chk("t3_before_pause", b_cnt[31:0], 7);
    b_pause = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t3_paused_count", b_cnt[31:0], 7);
    end
    b_pause = 1'b0;
    step();
    chk("t3_resumed", b_cnt[31:0], 6);
    repeat (6) step();
    chk("t3_done", b_done[0], 1);

    // Collisions: restart on the expiry cycle, start+stop, stop alone.
    b_load[31:0] = 32'd3; b_start[0] = 1'b1;
    step();
    b_start[0] = 1'b0;
    repeat (2) step();
    chk("t4_count_at_one", b_cnt[31:0], 1);
    b_load[31:0] = 32'd5; b_start[0] = 1'b1;
    step();
    chk("t4_restart_count", b_cnt[31:0], 5);
    chk("t4_restart_no_expire", b_exp[0], 0);
    chk("t4_restart_running", b_run[0], 1);
    b_load[31:0] = 32'd4; b_start[0] = 1'b1; b_stop[0] = 1'b1;
    step();
    chk("t4_start_wins_run", b_run[0], 1);
    chk("t4_start_wins_count", b_cnt[31:0], 4);
    b_start[0] = 1'b0;
    step();
    b_stop[0] = 1'b0;
    chk("t4_stop_idle", b_run[0], 0);
    chk("t4_stop_count_held", b_cnt[31:0], 4);
    chk("t4_stop_done_low", b_done[0], 0);

    // Zero-load start in DONE is ignored; stop then clears done.
    b_load[31:0] = 32'd2; b_start[0] = 1'b1;
    step();
    s = cyc;
    b_start[0] = 1'b0;
    push(1'b1, 0, 2'b01, 32'd0, 1'b1, s + 2);
    repeat (2) step();
    chk("t5_done", b_done[0], 1);
    b_load[31:0] = 32'd0; b_start[0] = 1'b1;
    step();
    b_start[0] = 1'b0;
    chk("t5_zero_load_done", b_done[0], 1);
    chk("t5_zero_load_count", b_cnt[31:0], 0);
    chk("t5_zero_load_idle", b_run[0], 0);
    b_stop[0] = 1'b1;
    step();
    b_stop[0] = 1'b0;
    chk("t5_stop_clears_done", b_done[0], 0);

    // Asynchronous reset in the middle of a count.
    b_load = {32'd7, 32'd10}; b_per = 2'b10; b_start = 2'b11;
    a_load[31:0] = 32'd9; a_start[0] = 1'b1;
    step();
    b_start = '0; a_start = '0;
    step();
    chk("t5_b_counting", b_run, 2'b11);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_async_a", {a_cnt[31:0] | a_cnt[63:32], 24'd0, a_run, a_done, a_exp}, 64'd0);
    chk("t5_async_b", {b_cnt[31:0] | b_cnt[63:32], 24'd0, b_run, b_done, b_exp}, 64'd0);
    step();
    resetn = 1'b1;
    step();
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
